ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 device-to-host receiver.
- Decodes full 11-bit frames: start 0, 8 data bits LSB-first, odd parity, stop 1.
- Checks parity, framing and inter-edge timeout, and buffers good scan-code bytes in a first-word-fall-through FIFO.
- Sits between the PS/2 pins and the keyboard/console logic, so consumers pop bytes at their own pace.

---
 rtl/ps2_pkg.sv | 5 +
 rtl/ps2_rx_fifo_if.sv | 26 ++
 rtl/sync_fifo.sv | 42 ++++
 rtl/ps2_rx_fifo.sv | 109 ++++++++++
 tb/tb_ps2_rx_fifo.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
  localparam int PS2_DATA_BITS = 8;
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 pins, byte pop port and error pulses of the receiver
interface ps2_rx_fifo_if
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic                     ps2_clk;
  logic                     ps2_data;
  logic                     rd_en;
  logic [PS2_DATA_BITS-1:0] rd_data;
  logic                     rd_valid;
  logic [CW-1:0]            fifo_count;
  logic                     parity_err;
  logic                     frame_err;
  logic                     timeout_err;
  logic                     overflow;
  modport master (
    output ps2_clk, ps2_data, rd_en,
    input  rd_data, rd_valid, fifo_count, parity_err, frame_err, timeout_err, overflow
  );
  modport slave (
    input  ps2_clk, ps2_data, rd_en,
    output rd_data, rd_valid, fifo_count, parity_err, frame_err, timeout_err, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-cycle push
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;
  assign empty   = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver with parity/framing/timeout checks
// feeding good scan-code bytes into a FWFT byte FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          rst,
  ps2_rx_fifo_if.slave ps2
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [SYNC_STAGES-1:0]   clk_sync_q, dat_sync_q;
  logic                     clk_prev_q;
  ps2_rx_state_t            state_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shift_q;
  logic                     par_q;
  logic [TW-1:0]            tmo_q;
  logic                     perr_q, ferr_q, terr_q, ovf_q;
  logic                     fall, din, push, full, empty;
  logic [CW-1:0]            count;
  assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign din  = dat_sync_q[SYNC_STAGES-1];
  assign push = fall & (state_q == STOP) & din & ^{shift_q, par_q};
  // Loading ones on reset models an idle bus, so release never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2.ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2.ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
      ovf_q  <= push & full & ~ps2.rd_en;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            state_q   <= din ? IDLE : DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {din, shift_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
          end
          PARITY: begin
            par_q   <= din;
            state_q <= STOP;
          end
          STOP: begin
            ferr_q  <= ~din;
            perr_q  <= din & ~^{shift_q, par_q};
            state_q <= IDLE;
          end
        endcase
      end else if (state_q != IDLE) begin
        // The pulse fires in the very cycle the counter would reach TIMEOUT_CYCLES-1.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
          terr_q  <= 1'b1;
          state_q <= IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end
  sync_fifo #(.DATA_W(PS2_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (ps2.rd_en),
    .rdata (ps2.rd_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign ps2.rd_valid    = ~empty;
  assign ps2.fifo_count  = count;
  assign ps2.parity_err  = perr_q;
  assign ps2.frame_err   = ferr_q;
  assign ps2.timeout_err = terr_q;
  assign ps2.overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frame table plus hand-written timeout, pop and reset sequences
module tb_ps2_rx_fifo;
  localparam int SS   = 2;
  localparam int FD   = 4;
  localparam int TO   = 1000;
  localparam int HALF = 50;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ps2_rx_fifo_if #(.FIFO_DEPTH(FD)) bus();
  ps2_rx_fifo #(.SYNC_STAGES(SS), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .ps2 (bus)
  );
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       stop;
    logic       pop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
    int         exp_perr;
    int         exp_ferr;
    int         exp_ovf;
  } vec_t;
  vec_t vecs [18];
  logic       s_valid;
  logic [7:0] s_data;
  int         s_count;
  int         n_perr, n_ferr, n_terr, n_ovf;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_tally();
    n_perr = 0; n_ferr = 0; n_terr = 0; n_ovf = 0;
  endtask
  task automatic tally();
    n_perr += int'(bus.parity_err);
    n_ferr += int'(bus.frame_err);
    n_terr += int'(bus.timeout_err);
    n_ovf  += int'(bus.overflow);
  endtask
  task automatic drive_bit(input logic d);
    @(negedge clk);
    bus.ps2_data = d;
    wait_clks(HALF);
    bus.ps2_clk = 1'b0;
    wait_clks(HALF);
    bus.ps2_clk = 1'b1;
  endtask
  // Samples k=1.. are taken 1 time unit after each posedge following the final clk-low drive;
  // the stop fall is seen at k=SS, so the push/pulse edge is k=SS+1.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input logic pop);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
    @(negedge clk);
    bus.ps2_data = bits[10];
    wait_clks(HALF);
    bus.ps2_clk = 1'b0;
    clear_tally();
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      tally();
      if (k == SS && pop) bus.rd_en = 1'b1;
      if (k == SS + 1) begin
        s_valid = bus.rd_valid;
        s_data  = bus.rd_data;
        s_count = int'(bus.fifo_count);
        bus.rd_en = 1'b0;
      end
    end
    wait_clks(HALF - 10);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clks(20);
  endtask
  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, "_valid"}, bus.rd_valid, 1'b1);
    check({name, "_data"}, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask
  task automatic expect_empty(input string name);
    @(negedge clk);
    check({name, "_valid"}, bus.rd_valid, 1'b0);
    check({name, "_count"}, bus.fifo_count, 0);
  endtask
  task automatic timeout_test();
    int n;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge clk);
    bus.ps2_data = 1'b1;
    wait_clks(HALF);
    bus.ps2_clk = 1'b0;
    clear_tally();
    n = 0;
    while (n < TO + 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == HALF) bus.ps2_clk = 1'b1;
      if (bus.timeout_err) break;
      tally();
    end
    check("timeout_latency", n, SS + TO);
    check("timeout_other_pulses", n_perr + n_ferr + n_ovf, 0);
    @(posedge clk);
    #1;
    check("timeout_one_cycle", bus.timeout_err, 1'b0);
    check("timeout_count", bus.fifo_count, 0);
    wait_clks(20);
  endtask
  task automatic reset_mid_frame();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    clear_tally();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      tally();
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ps2_data = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      tally();
    end
    check("rst_mid_pulses", n_perr + n_ferr + n_terr + n_ovf, 0);
    check("rst_mid_count", bus.fifo_count, 0);
    check("rst_mid_valid", bus.rd_valid, 1'b0);
    check("rst_mid_data", bus.rd_data, 8'h00);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1, 0, 0};
    vecs[2]  = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1, 0, 0, 0};
    vecs[3]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0};
    vecs[4]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0};
    vecs[5]  = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b1, 8'h29, 1, 0, 0, 0};
    vecs[6]  = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1, 0, 0, 0};
    vecs[7]  = '{8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 2, 0, 0, 0};
    vecs[8]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 3, 0, 0, 0};
    vecs[9]  = '{8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 4, 0, 0, 0};
    vecs[10] = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 4, 0, 0, 1};
    vecs[11] = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1, 0, 0, 0};
    vecs[12] = '{8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 2, 0, 0, 0};
    vecs[13] = '{8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 3, 0, 0, 0};
    vecs[14] = '{8'h40, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 4, 0, 0, 0};
    vecs[15] = '{8'h50, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 4, 0, 0, 0};
    vecs[16] = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1, 0, 0, 0};
    vecs[17] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 0};
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd_en    = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    check("reset_valid", bus.rd_valid, 1'b0);
    check("reset_count", bus.fifo_count, 0);
    check("reset_data", bus.rd_data, 8'h00);
    check("reset_pulses", {bus.parity_err, bus.frame_err, bus.timeout_err, bus.overflow}, 4'b0);
    for (int i = 0; i < 18; i++) begin
      send_frame(vecs[i].b, vecs[i].par, vecs[i].stop, vecs[i].pop);
      check($sformatf("v%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("v%0d_data", i), s_data, vecs[i].exp_data);
      check($sformatf("v%0d_count", i), s_count, vecs[i].exp_count);
      check($sformatf("v%0d_perr", i), n_perr, vecs[i].exp_perr);
      check($sformatf("v%0d_ferr", i), n_ferr, vecs[i].exp_ferr);
      check($sformatf("v%0d_terr", i), n_terr, 0);
      check($sformatf("v%0d_ovf", i), n_ovf, vecs[i].exp_ovf);
      case (i)
        0, 2, 5: begin
          pop_expect($sformatf("v%0d_pop", i), vecs[i].exp_data);
          expect_empty($sformatf("v%0d_after_pop", i));
        end
        4: timeout_test();
        10: begin
          pop_expect("ovf_pop0", 8'h01);
          pop_expect("ovf_pop1", 8'h02);
          pop_expect("ovf_pop2", 8'h03);
          pop_expect("ovf_pop3", 8'h04);
          expect_empty("ovf_drained");
          bus.rd_en = 1'b1;
          @(negedge clk);
          bus.rd_en = 1'b0;
          expect_empty("pop_when_empty");
        end
        15: begin
          pop_expect("fullpop_pop0", 8'h20);
          pop_expect("fullpop_pop1", 8'h30);
          pop_expect("fullpop_pop2", 8'h40);
          pop_expect("fullpop_pop3", 8'h50);
          expect_empty("fullpop_drained");
        end
        16: reset_mid_frame();
        default: ;
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
